// File: rtl/ws2812_serializer.sv
// ws2812_serializer: single-wire WS2812B line driver.
//
// Takes one 24-bit colour word per valid/ready handshake and shifts it out
// MSB first as NRZ pulses on `led`. A word accepted with `latch` set is
// followed by a strip reset (latch) gap of RESET_CYC low cycles. The same
// gap is always run after reset, so a strip interrupted mid-word is cleanly
// latched before new data arrives.
//
// Optional feature macro: WS2812_BRIGHT_EN
//   defined   -> `bright` input exists; each colour byte is right-shifted by
//                `bright` when the word is accepted (0 = full, 3 = 1/8).
//   undefined -> no `bright` port; words are sent unmodified.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RST_GAP | led low for RESET_CYC cycles (strip latch), ready = 0
// IDLE    | waiting for a word, ready = 1, led low
// HIGH    | high phase of the current bit (T1H_CYC or T0H_CYC cycles)
// LOW     | remainder of the current bit period, led low

module ws2812_serializer #(
    parameter int T0H_CYC   = 8,
    parameter int T1H_CYC   = 16,
    parameter int BIT_CYC   = 25,
    parameter int RESET_CYC = 6000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
`ifdef WS2812_BRIGHT_EN
    input  logic [1:0]  bright,
`endif
    output logic        ready,
    output logic        led
);

    typedef enum logic [1:0] {
        RST_GAP = 2'd0,
        IDLE    = 2'd1,
        HIGH    = 2'd2,
        LOW     = 2'd3
    } state_t;

    // Down-counter load values: a phase of K cycles loads K-1 and ends at 0.
    localparam logic [7:0]  T0H_LD   = 8'(T0H_CYC - 1);
    localparam logic [7:0]  T1H_LD   = 8'(T1H_CYC - 1);
    localparam logic [7:0]  T0L_LD   = 8'(BIT_CYC - T0H_CYC - 1);
    localparam logic [7:0]  T1L_LD   = 8'(BIT_CYC - T1H_CYC - 1);
    localparam logic [12:0] GAP_LAST = 13'(RESET_CYC - 1);
    localparam logic [4:0]  LAST_BIT = 5'd23;

    state_t      state_q, state_d;
    logic [23:0] shreg_q, shreg_d;
    logic        latch_q, latch_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cyc_cnt_q, cyc_cnt_d;
    logic [12:0] gap_cnt_q, gap_cnt_d;
    logic        led_q;
    logic [23:0] load_word;

    // Word as it enters the shift register (optionally brightness-scaled).
    always_comb begin
`ifdef WS2812_BRIGHT_EN
        load_word = {data_in[23:16] >> bright,
                     data_in[15:8]  >> bright,
                     data_in[7:0]   >> bright};
`else
        load_word = data_in;
`endif
    end

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        latch_d   = latch_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ready     = 1'b0;

        case (state_q)
            RST_GAP: begin
                // Gap counts up from a cleared value so that the async reset
                // state and the latch entry behave identically.
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 13'd1;
                end
            end

            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    shreg_d   = load_word;
                    latch_d   = latch;
                    bit_cnt_d = '0;
                    cyc_cnt_d = load_word[23] ? T1H_LD : T0H_LD;
                    state_d   = HIGH;
                end
            end

            HIGH: begin
                if (cyc_cnt_q == 8'd0) begin
                    cyc_cnt_d = shreg_q[23] ? T1L_LD : T0L_LD;
                    state_d   = LOW;
                end else begin
                    cyc_cnt_d = cyc_cnt_q - 8'd1;
                end
            end

            LOW: begin
                if (cyc_cnt_q == 8'd0) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        // Next bit is shreg[22] before the shift lands.
                        shreg_d   = {shreg_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        cyc_cnt_d = shreg_q[22] ? T1H_LD : T0H_LD;
                        state_d   = HIGH;
                    end else if (latch_q) begin
                        gap_cnt_d = '0;
                        state_d   = RST_GAP;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = RST_GAP;
            end
        endcase
    end

    // State and datapath registers; led is registered from the next state so
    // it rises in the first cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_GAP;
            shreg_q   <= '0;
            latch_q   <= 1'b0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            gap_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            latch_q   <= latch_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            led_q     <= (state_d == HIGH);
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Testbench for ws2812_serializer: directed words, scoreboard of expected
// words, and a monitor that decodes the led waveform back into words.

module tb_ws2812_serializer;

    localparam int T0H = 8;
    localparam int T1H = 16;
    localparam int BIT = 25;
    localparam int RST = 6000;
    localparam int WORD_CYC = 24 * BIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] data_in = '0;
    logic        valid = 1'b0;
    logic        latch = 1'b0;
    logic        ready;
    logic        led;
`ifdef WS2812_BRIGHT_EN
    logic [1:0]  bright = 2'd0;
`endif

    typedef struct packed {
        logic [23:0] word;
        logic        lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    ws2812_serializer #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BIT), .RESET_CYC(RST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .valid(valid),
        .latch(latch),
`ifdef WS2812_BRIGHT_EN
        .bright(bright),
`endif
        .ready(ready),
        .led(led)
    );

    // 20 MHz clock
    always #25 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Counts edges until ready is seen high just after an edge.
    task automatic wait_ready(input int limit, output int n, output bit saw_led);
        n = 0;
        saw_led = 1'b0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (led) saw_led = 1'b1;
            if (ready) break;
        end
    endtask

    // Offers one word on a ready cycle; checks the accept-cycle response.
    task automatic send(input logic [23:0] w, input logic l, input bit push,
                        input logic [23:0] exp_w);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", ready, 1);
        data_in = w;
        latch   = l;
        valid   = 1'b1;
        if (push) begin
            e.word = exp_w;
            e.lat  = l;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("accept_ready_low", ready, 0);
        check("accept_led_high", led, 1);
    endtask

    // Monitor: decode every led word, compare against the scoreboard.
    int   mon_h[24];
    int   mon_l[24];
    logic [23:0] mon_word;
    bit   mon_abort;
    exp_t mon_e;
    int   mon_err;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (led && rst_n) begin
                mon_word  = '0;
                mon_abort = 1'b0;
                for (int i = 0; i < 24 && !mon_abort; i++) begin
                    mon_h[i] = 0;
                    mon_l[i] = 0;
                    while (led && rst_n && mon_h[i] < 300) begin
                        mon_h[i]++;
                        @(negedge clk);
                    end
                    if (!rst_n) mon_abort = 1'b1;
                    mon_word = {mon_word[22:0], (mon_h[i] > 12)};
                    if (!mon_abort) begin
                        while (!led && rst_n && !(i == 23 && ready) && mon_l[i] < 10000) begin
                            mon_l[i]++;
                            @(negedge clk);
                        end
                    end
                    if (!rst_n) mon_abort = 1'b1;
                end
                if (!mon_abort) begin
                    if (exp_q.size() == 0) begin
                        check("word_expected", exp_q.size(), 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("word_value", mon_word, mon_e.word);
                        mon_err = 0;
                        for (int i = 0; i < 24; i++) begin
                            if (mon_h[i] != (mon_e.word[23-i] ? T1H : T0H)) mon_err++;
                            if (i < 23 && mon_h[i] + mon_l[i] != BIT) mon_err++;
                        end
                        check("pulse_width_errors", mon_err, 0);
                        check("tail_low_cycles", mon_l[23],
                              (BIT - (mon_e.word[0] ? T1H : T0H)) + (mon_e.lat ? RST : 0));
                    end
                end
            end
        end
    end

    int n;
    bit saw;
    int drop;

    initial begin : stimulus
        // Power-on reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_led", led, 0);
        rst_n = 1'b1;
        wait_ready(RST + 50, n, saw);
        check("reset_gap_len", n, RST);
        check("reset_gap_led", saw, 0);
        drop = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ready) drop++;
        end
        check("ready_stays_high", drop, 0);

        // Mixed bits, no latch
        send(24'hFF00AA, 1'b0, 1'b1, 24'hFF00AA);
        wait_ready(WORD_CYC + 50, n, saw);
        check("latency_ff00aa", n, WORD_CYC);

        // Last bit 1, with latch gap
        send(24'h000001, 1'b1, 1'b1, 24'h000001);
        wait_ready(WORD_CYC + RST + 50, n, saw);
        check("latency_latch", n, WORD_CYC + RST);

        // valid pulsed while busy is ignored
        send(24'h5A3C81, 1'b0, 1'b1, 24'h5A3C81);
        repeat (100) @(posedge clk);
        #1;
        data_in = 24'hFFFFFF;
        latch   = 1'b1;
        valid   = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        valid = 1'b0;
        latch = 1'b0;
        wait_ready(WORD_CYC, n, saw);
        check("latency_busy_valid", n, WORD_CYC - 150);

        // valid held high: back-to-back words, one idle cycle between
        send(24'h800001, 1'b0, 1'b1, 24'h800001);
        data_in = 24'h7FFFFE;
        valid   = 1'b1;
        begin
            exp_t e;
            e.word = 24'h7FFFFE;
            e.lat  = 1'b0;
            exp_q.push_back(e);
        end
        wait_ready(WORD_CYC + 50, n, saw);
        check("latency_held_1st", n, WORD_CYC);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("held_accept_ready", ready, 0);
        check("held_accept_led", led, 1);
        wait_ready(WORD_CYC + 50, n, saw);
        check("latency_held_2nd", n, WORD_CYC);

`ifdef WS2812_BRIGHT_EN
        bright = 2'd2;
        send(24'hFF8040, 1'b0, 1'b1, 24'h3F2010);
        wait_ready(WORD_CYC + 50, n, saw);
        check("latency_bright", n, WORD_CYC);
        bright = 2'd0;
`endif

        // Async reset in the middle of bit 10
        send(24'hFFFFFF, 1'b0, 1'b0, 24'h0);
        repeat (255) @(posedge clk);
        #5;
        check("midword_led_high", led, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_led", led, 0);
        check("async_reset_ready", ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(RST + 50, n, saw);
        check("midword_gap_len", n, RST);
        check("midword_gap_led", saw, 0);

        // Normal operation resumes
        send(24'h00FF00, 1'b0, 1'b1, 24'h00FF00);
        wait_ready(WORD_CYC + 50, n, saw);
        check("latency_after_reset", n, WORD_CYC);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
